// File: rtl/m3_pkg.sv
// Shared constants, state type and Hall decoding helpers for the m3 rotor-position blocks.
`timescale 1ns/1ps
package m3_pkg;

  localparam int PERIOD_W = 22;
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = 22'd4000000;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} stateT;

  typedef struct packed {
    logic       illegal;
    logic [2:0] sector;
  } hallDecT;

  function automatic hallDecT decodeHall(input logic [2:0] code);
    hallDecT dec;
    dec.illegal = 1'b0;
    dec.sector  = 3'd0;
    case (code)
      3'b001:  dec.sector = 3'd0;
      3'b011:  dec.sector = 3'd1;
      3'b010:  dec.sector = 3'd2;
      3'b110:  dec.sector = 3'd3;
      3'b100:  dec.sector = 3'd4;
      3'b101:  dec.sector = 3'd5;
      default: dec.illegal = 1'b1;
    endcase
    return dec;
  endfunction

  // (newSector - oldSector) mod 6: 1 = forward step, 5 = reverse step, 2..4 = skip.
  function automatic logic [2:0] sectorDelta(input logic [2:0] newSector,
                                             input logic [2:0] oldSector);
    logic [3:0] diff;
    diff = {1'b0, newSector} + 4'd6 - {1'b0, oldSector};
    if (diff >= 4'd6) diff = diff - 4'd6;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/m3_hall_sync_debounce.sv
// Two-flop synchroniser and stability filter for the Hall inputs; strobes once per newly
// accepted code.
`timescale 1ns/1ps
module m3_hall_sync_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic       clearI,
  input  logic [2:0] hallI,
  output logic [2:0] codeO,
  output logic       strobeO
);

  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  logic [2:0]    sync1Reg;
  logic [2:0]    sync2Reg;
  logic [2:0]    acceptedReg;
  logic [SW-1:0] stableReg;

  // stableReg = cycles sync2Reg has held its current value, saturating at DEBOUNCE.
  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      sync1Reg    <= 3'b000;
      sync2Reg    <= 3'b000;
      acceptedReg <= 3'b000;
      stableReg   <= '0;
    end else if (clearI) begin
      sync1Reg    <= 3'b000;
      sync2Reg    <= 3'b000;
      acceptedReg <= 3'b000;
      stableReg   <= '0;
    end else begin
      sync1Reg <= hallI;
      sync2Reg <= sync1Reg;
      if (sync1Reg != sync2Reg)
        stableReg <= '0;
      else if (stableReg != STABLE_MAX)
        stableReg <= stableReg + SW'(1);
      if (strobeO)
        acceptedReg <= sync2Reg;
    end
  end

  assign strobeO = (stableReg == STABLE_MAX) && (sync2Reg != acceptedReg);
  assign codeO   = sync2Reg;

endmodule

// File: rtl/m3_hall_step_decoder.sv
// Hall-sensor rotor position decoder: sector, direction, step/round period, stall and
// sequence-error detection.
`timescale 1ns/1ps
module m3_hall_step_decoder #(
  parameter int                    PERIOD_W   = m3_pkg::PERIOD_W,
  parameter logic [PERIOD_W-1:0]   PERIOD_MAX = m3_pkg::PERIOD_MAX,
  parameter int                    DEBOUNCE   = 8
) (
  input  logic                  clkI,
  input  logic                  rstI,
  input  logic                  enableI,
  input  logic [2:0]            hallI,
  output logic [2:0]            sectorO,
  output logic                  sectorValidO,
  output logic                  dirO,
  output logic                  stepPulseO,
  output logic [PERIOD_W-1:0]   stepPeriodO,
  output logic                  roundPulseO,
  output logic [PERIOD_W+2:0]   roundPeriodO,
  output logic                  stallO,
  output logic                  hallErrO
);

  import m3_pkg::*;

  localparam int ACC_W = PERIOD_W + 3;

  logic [2:0]          hallCode;
  logic                hallStrobe;
  hallDecT             dec;
  logic [2:0]          delta;
  logic                isFwd;
  logic                adjacent;
  logic                stallHit;
  logic [ACC_W-1:0]    accSum;

  stateT               stateReg;
  logic [2:0]          sectorReg;
  logic                validReg;
  logic                dirReg;
  logic                stepPulseReg;
  logic [PERIOD_W-1:0] stepPeriodReg;
  logic                roundPulseReg;
  logic [ACC_W-1:0]    roundPeriodReg;
  logic                stallReg;
  logic                hallErrReg;
  logic [PERIOD_W-1:0] cntReg;
  logic [ACC_W-1:0]    accReg;
  logic [2:0]          stepCntReg;

  m3_hall_sync_debounce #(.DEBOUNCE(DEBOUNCE)) uSyncDebounce (
    .clkI    (clkI),
    .rstI    (rstI),
    .clearI  (~enableI),
    .hallI   (hallI),
    .codeO   (hallCode),
    .strobeO (hallStrobe)
  );

  assign dec      = decodeHall(hallCode);
  assign delta    = sectorDelta(dec.sector, sectorReg);
  assign isFwd    = (delta == 3'd1);
  assign adjacent = (delta == 3'd1) || (delta == 3'd5);
  assign stallHit = validReg && (cntReg == PERIOD_MAX);
  assign accSum   = accReg + ACC_W'(cntReg);

  always_ff @(posedge clkI or posedge rstI) begin
    if (rstI) begin
      stateReg       <= IDLE;
      sectorReg      <= 3'd0;
      validReg       <= 1'b0;
      dirReg         <= 1'b1;
      stepPulseReg   <= 1'b0;
      stepPeriodReg  <= '0;
      roundPulseReg  <= 1'b0;
      roundPeriodReg <= '0;
      stallReg       <= 1'b0;
      hallErrReg     <= 1'b0;
      cntReg         <= '0;
      accReg         <= '0;
      stepCntReg     <= 3'd0;
    end else if (!enableI) begin
      stateReg       <= IDLE;
      sectorReg      <= 3'd0;
      validReg       <= 1'b0;
      dirReg         <= 1'b1;
      stepPulseReg   <= 1'b0;
      stepPeriodReg  <= '0;
      roundPulseReg  <= 1'b0;
      roundPeriodReg <= '0;
      stallReg       <= 1'b0;
      hallErrReg     <= 1'b0;
      cntReg         <= '0;
      accReg         <= '0;
      stepCntReg     <= 3'd0;
    end else if (stateReg == IDLE) begin
      stateReg <= ACQUIRE;
    end else begin
      stepPulseReg  <= 1'b0;
      roundPulseReg <= 1'b0;
      hallErrReg    <= 1'b0;

      if (hallStrobe)
        cntReg <= PERIOD_W'(1);
      else if (cntReg != PERIOD_MAX)
        cntReg <= cntReg + PERIOD_W'(1);

      if (hallStrobe && dec.illegal) begin
        hallErrReg <= 1'b1;
        validReg   <= 1'b0;
        stateReg   <= ACQUIRE;
        accReg     <= '0;
        stepCntReg <= 3'd0;
      end else if (hallStrobe) begin
        stallReg  <= 1'b0;
        sectorReg <= dec.sector;
        validReg  <= 1'b1;
        if (!validReg || !adjacent) begin
          // Fresh acquisition or a skipped sector; only a skip while tracking is an error.
          hallErrReg <= validReg && (stateReg == TRACK);
          stateReg   <= ACQUIRE;
          accReg     <= '0;
          stepCntReg <= 3'd0;
        end else begin
          stepPulseReg  <= 1'b1;
          stepPeriodReg <= cntReg;
          dirReg        <= isFwd;
          stateReg      <= TRACK;
          if (stateReg == TRACK && isFwd == dirReg) begin
            if (stepCntReg == 3'd5) begin
              roundPeriodReg <= accSum;
              roundPulseReg  <= 1'b1;
              accReg         <= '0;
              stepCntReg     <= 3'd0;
            end else begin
              accReg     <= accSum;
              stepCntReg <= stepCntReg + 3'd1;
            end
          end else begin
            // First step after acquire or a reversal opens a new round.
            accReg     <= ACC_W'(cntReg);
            stepCntReg <= 3'd1;
          end
        end
      end else if (stallHit) begin
        stallReg      <= 1'b1;
        stepPeriodReg <= PERIOD_MAX;
        accReg        <= '0;
        stepCntReg    <= 3'd0;
        stateReg      <= ACQUIRE;
      end
    end
  end

  assign sectorO      = sectorReg;
  assign sectorValidO = validReg;
  assign dirO         = dirReg;
  assign stepPulseO   = stepPulseReg;
  assign stepPeriodO  = stepPeriodReg;
  assign roundPulseO  = roundPulseReg;
  assign roundPeriodO = roundPeriodReg;
  assign stallO       = stallReg;
  assign hallErrO     = hallErrReg;

endmodule

// File: tb/tb_m3_hall_step_decoder.sv
// Self-checking bench for m3_hall_step_decoder against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_m3_hall_step_decoder;

  localparam int PW   = 22;
  localparam int DEB  = 8;
  localparam int PMAX = 5000;

  logic          clkI = 1'b0;
  logic          rstI;
  logic          enableI;
  logic [2:0]    hallI;
  logic [2:0]    sectorO;
  logic          sectorValidO;
  logic          dirO;
  logic          stepPulseO;
  logic [PW-1:0] stepPeriodO;
  logic          roundPulseO;
  logic [PW+2:0] roundPeriodO;
  logic          stallO;
  logic          hallErrO;

  m3_hall_step_decoder #(
    .PERIOD_W   (PW),
    .PERIOD_MAX (22'd5000),
    .DEBOUNCE   (DEB)
  ) dut (
    .clkI         (clkI),
    .rstI         (rstI),
    .enableI      (enableI),
    .hallI        (hallI),
    .sectorO      (sectorO),
    .sectorValidO (sectorValidO),
    .dirO         (dirO),
    .stepPulseO   (stepPulseO),
    .stepPeriodO  (stepPeriodO),
    .roundPulseO  (roundPulseO),
    .roundPeriodO (roundPeriodO),
    .stallO       (stallO),
    .hallErrO     (hallErrO)
  );

  always #500 clkI = ~clkI;

  int cyc = 0;
  always @(posedge clkI) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Behavioural model state
  int sectorOf [8] = '{-1, 0, 2, 1, 4, 5, 3, -1};
  int codeOf   [6] = '{1, 3, 2, 6, 4, 5};
  int mSector, mValid, mDir, mTrack, mStall, mStepPer, mRoundPer, lastAcc;
  int ePulse, eRound, eErr;
  int run [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clkI);
    #1;
  endtask

  task automatic modelReset();
    mSector = 0; mValid = 0; mDir = 1; mTrack = 0; mStall = 0;
    mStepPer = 0; mRoundPer = 0; ePulse = 0; eRound = 0; eErr = 0;
    run.delete();
  endtask

  task automatic modelAccept(input logic [2:0] code);
    int s, d, nd, per;
    s   = sectorOf[code];
    per = cyc - lastAcc;
    if (per > PMAX) per = PMAX;
    lastAcc = cyc;
    ePulse = 0; eRound = 0; eErr = 0;
    if (s < 0) begin
      eErr = 1; mValid = 0; mTrack = 0; run.delete();
    end else begin
      d = (s - mSector + 6) % 6;
      mStall = 0;
      if (mValid != 0 && (d == 1 || d == 5)) begin
        nd = (d == 1) ? 1 : 0;
        if (mTrack == 0 || nd != mDir) run.delete();
        mTrack = 1; mDir = nd; ePulse = 1; mStepPer = per;
        run.push_back(per);
        if (run.size() == 6) begin
          eRound = 1; mRoundPer = run.sum(); run.delete();
        end
      end else begin
        if (mValid != 0 && mTrack != 0) eErr = 1;
        mTrack = 0; mValid = 1; run.delete();
      end
      mSector = s;
    end
  endtask

  task automatic modelStall();
    mStall = 1; mStepPer = PMAX; mTrack = 0; run.delete();
    ePulse = 0; eRound = 0; eErr = 0;
  endtask

  task automatic checkAll(input string tag);
    check($sformatf("%s_sector", tag), 32'(sectorO), mSector);
    check($sformatf("%s_valid", tag), 32'(sectorValidO), mValid);
    check($sformatf("%s_dir", tag), 32'(dirO), mDir);
    check($sformatf("%s_steppulse", tag), 32'(stepPulseO), ePulse);
    check($sformatf("%s_roundpulse", tag), 32'(roundPulseO), eRound);
    check($sformatf("%s_hallerr", tag), 32'(hallErrO), eErr);
    check($sformatf("%s_stepperiod", tag), 32'(stepPeriodO), mStepPer);
    check($sformatf("%s_roundperiod", tag), 32'(roundPeriodO), mRoundPer);
    check($sformatf("%s_stall", tag), 32'(stallO), mStall);
  endtask

  // Drive a code, verify nothing happens one cycle early, full check at 2+DEB+1,
  // pulses gone the cycle after, then hold until 'hold' cycles after the drive.
  task automatic stepTo(input logic [2:0] code, input int hold, input string tag);
    hallI = code;
    repeat (DEB + 2) tick();
    check($sformatf("%s_early", tag), 32'({stepPulseO, roundPulseO, hallErrO}), 0);
    tick();
    modelAccept(code);
    checkAll(tag);
    tick();
    check($sformatf("%s_width", tag), 32'({stepPulseO, roundPulseO, hallErrO}), 0);
    repeat (hold - DEB - 4) tick();
  endtask

  task automatic reacquire(input string tag, input int hold);
    repeat (DEB + 2) tick();
    check($sformatf("%s_lat_early", tag), 32'(sectorValidO), 0);
    tick();
    modelAccept(hallI);
    checkAll(tag);
    repeat (hold - DEB - 3) tick();
  endtask

  task automatic randWalk(input int n, input string tag);
    int wdir, s;
    wdir = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) == 0) wdir = 1 - wdir;
      s = (mSector + ((wdir != 0) ? 1 : 5)) % 6;
      stepTo(3'(codeOf[s]), int'($urandom_range(20, 900)), $sformatf("%s%0d", tag, i));
    end
  endtask

  initial begin
    int np;
    rstI = 1'b1; enableI = 1'b0; hallI = 3'b001; lastAcc = 0;
    modelReset();
    repeat (3) tick();
    checkAll("reset");

    enableI = 1'b1; rstI = 1'b0;
    reacquire("acq", 1000);

    for (int i = 1; i <= 6; i++) stepTo(3'(codeOf[i % 6]), 1000, $sformatf("fwd%0d", i));

    stepTo(3'(codeOf[1]), 1000, "prerev1");
    stepTo(3'(codeOf[2]), 1000, "prerev2");
    for (int i = 0; i < 6; i++) stepTo(3'(codeOf[(7 - i) % 6]), 800, $sformatf("rev%0d", i));
    stepTo(3'(codeOf[1]), 700, "rev6");
    stepTo(3'(codeOf[0]), 700, "rev7");

    // 5-cycle glitch to a neighbouring code must be filtered out
    np = 0;
    hallI = 3'b011;
    repeat (5) begin tick(); np += int'(stepPulseO) + int'(roundPulseO) + int'(hallErrO); end
    hallI = 3'b001;
    repeat (30) begin tick(); np += int'(stepPulseO) + int'(roundPulseO) + int'(hallErrO); end
    check("glitch_pulses", np, 0);
    check("glitch_sector", 32'(sectorO), mSector);

    stepTo(3'b110, 600, "skip");
    check("skip_state", 32'(dut.stateReg), 32'(m3_pkg::ACQUIRE));

    stepTo(3'b111, 20, "illegal");
    stepTo(3'b001, 1000, "relegal");

    randWalk(20, "rwa");

    while (cyc < lastAcc + PMAX - 1) tick();
    check("stall_early", 32'(stallO), 0);
    tick();
    modelStall();
    checkAll("stall");
    repeat (100) tick();
    stepTo(3'(codeOf[(mSector + 1) % 6]), 900, "after_stall");

    randWalk(20, "rwb");

    stepTo(3'(codeOf[(mSector + 1) % 6]), 500, "pre_rst1");
    stepTo(3'(codeOf[(mSector + 1) % 6]), 500, "pre_rst2");
    rstI = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    repeat (3) tick();
    rstI = 1'b0;
    reacquire("rst_acq", 600);
    stepTo(3'(codeOf[(mSector + 5) % 6]), 600, "post_rst");

    stepTo(3'(codeOf[(mSector + 5) % 6]), 500, "pre_en1");
    enableI = 1'b0;
    tick();
    modelReset();
    checkAll("en_drop");
    repeat (3) tick();
    enableI = 1'b1;
    reacquire("reen", 600);
    stepTo(3'(codeOf[(mSector + 1) % 6]), 600, "post_reen");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/m3_hall_step_decoder.md
# m3_hall_step_decoder

Rotor-side counterpart of the open-loop commutation step generator in the 3-phase motor controller. It synchronises and debounces the three Hall sensor inputs and decodes them into a 6-sector rotor position. It also derives rotation direction, measures the per-step and per-round period in 1 MHz clock cycles, and flags stalls and illegal Hall sequences. Speed control logic uses its outputs as measured feedback against the commanded round length.

## Interface
- `PERIOD_W`, 22 — width of step period counters (cycles).
- `PERIOD_MAX`, 22'd4000000 — step period saturation / stall threshold (cycles).
- `DEBOUNCE`, 8 — cycles a synchronised Hall code must be stable before acceptance (≥1).
- `clkI` input 1 — 1 MHz system clock. One clock domain only.
- `rstI` input 1 — reset. Asynchronous and active-high.
- `enableI` input 1 — decoder enable. Low = synchronous clear to IDLE.
- `hallI` input 3 — raw Hall sensors {C,B,A}, asynchronous.
- `sectorO` output 3 — current rotor sector 0..5.
- `sectorValidO` output 1 — `sectorO` is trustworthy.
- `dirO` output 1 — 1 = forward (sector increments), 0 = reverse.
- `stepPulseO` output 1 — one-cycle pulse on each accepted adjacent-sector transition.
- `stepPeriodO` output PERIOD_W — cycles between the last two accepted transitions.
- `roundPulseO` output 1 — one-cycle pulse when 6 consecutive same-direction steps complete.
- `roundPeriodO` output PERIOD_W+3 — sum of the last 6 step periods.
- `stallO` output 1 — level: no transition for PERIOD_MAX cycles.
- `hallErrO` output 1 — one-cycle pulse on an illegal code or a sector skip.

## Operation
- Hall code map (CBA → sector): 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are illegal.
- Front end:
  - 2-flop synchroniser, then a stability counter.
  - A code is accepted once it has been unchanged for DEBOUNCE consecutive cycles and differs from the last accepted code.
  - An accepted code is processed exactly once.
- Period counter `cnt`:
  - Increments every cycle in ACQUIRE/TRACK and saturates at PERIOD_MAX.
  - Each accepted code sets `cnt` to 1.
- States:
  - **IDLE** (reset or `enableI`=0): all outputs are at their reset values. When `enableI`=1, go to ACQUIRE.
  - **ACQUIRE**:
    - First legal accepted code: load `sectorO`, set `sectorValidO`=1, clear `cnt`, and stay in ACQUIRE until an adjacent transition is seen.
    - First adjacent transition: set `dirO`, go to TRACK, assert `stepPulseO`, and load `stepPeriodO` ← `cnt`.
    - The first period after a stall, error or acquire is still reported.
  - **TRACK**:
    - New sector = old±1 mod 6:
      - Update `sectorO`, pulse `stepPulseO`, and load `stepPeriodO` ← `cnt`.
      - Add `cnt` to the round accumulator and increment the step count.
      - When the step count reaches 6, load `roundPeriodO`, pulse `roundPulseO`, and clear the accumulator and count.
    - The sign of the ±1 step is compared with `dirO`. If they differ (reversal):
      - Update `dirO`.
      - Clear the accumulator and count, then count the current step as the first of the new round.
      - `roundPeriodO` keeps its old value.
    - Non-adjacent legal code (skip of 2 or 3):
      - Pulse `hallErrO`, update `sectorO`, go to ACQUIRE, clear the accumulator.
      - `stepPeriodO` is not updated.
  - **Any enabled state**:
    - Illegal code accepted: pulse `hallErrO`, set `sectorValidO`=0, go to ACQUIRE; `sectorO` holds.
    - `cnt` reaches PERIOD_MAX (ACQUIRE or TRACK, with a sector known): set `stallO`=1, set `stepPeriodO`=PERIOD_MAX, clear the accumulator, go to ACQUIRE.
    - `stallO` clears on the next accepted legal code.
- Arithmetic:
  - The accumulator is PERIOD_W+3 bits; 6×PERIOD_MAX cannot overflow.
  - `cnt` never wraps.

## Timing
- Reset values (and the IDLE values):
  - `sectorO`=0, `sectorValidO`=0, `dirO`=1.
  - All pulses are 0.
  - `stepPeriodO`=0, `roundPeriodO`=0, `stallO`=0.
- Latency: `hallI` edge → updated `sectorO`/pulses = 2 (sync) + DEBOUNCE + 1 cycles.
- All outputs are registered. Pulses are exactly one cycle wide.
- A glitch shorter than DEBOUNCE cycles is ignored, and the stability counter restarts.
- Simultaneous stall threshold and accepted code in the same cycle: the code wins, and `stepPeriodO`=PERIOD_MAX.
- An `enableI` drop mid-round clears everything on the next edge.
- An `rstI` assertion clears everything immediately, with no clock needed.

## Structure
- Shared package `m3_pkg` holds:
  - PERIOD_W and PERIOD_MAX constants.
  - The Hall code→sector decode function, with an illegal flag.
  - The state enum {IDLE, ACQUIRE, TRACK}.
- Sub-module `m3_hall_sync_debounce`: synchroniser plus stability counter. It outputs the accepted code and a one-cycle acceptance strobe.

## Test plan
- **Forward rotation.** Stimulus: reset, enable, then drive codes 001,011,010,110,100,101,001 every 1000 cycles. Required: `dirO`=1; `stepPeriodO`=1000 from the 2nd transition; `roundPulseO` after 6 tracked steps with `roundPeriodO`=6000.
- **Reversal.** Stimulus: forward steps, then reverse. Required: `dirO`→0 on the first reverse step; no `roundPulseO` until 6 reverse steps; `roundPeriodO` unchanged meanwhile.
- **Glitch and skip.** Stimulus: a 5-cycle glitch to a neighbouring code. Required: ignored, no pulses. Stimulus: a jump 001→110. Required: `hallErrO` pulse, `sectorO`=3, state ACQUIRE.
- **Illegal code.** Stimulus: hold 111 for 20 cycles. Required: one `hallErrO` pulse and `sectorValidO`=0. Then 001: `sectorValidO`=1 and `sectorO`=0.
- **Stall.** Stimulus: no transition for PERIOD_MAX cycles. Required: `stallO`=1 and `stepPeriodO`=PERIOD_MAX. The next legal transition clears `stallO`.
- **Resets.** Stimulus: `rstI` pulse mid-round, and separately `enableI`=0. Required: all outputs at reset values; latency check is 2+DEBOUNCE+1 cycles after re-enable.
